proc_gen: RTL and testbench

Parametrised successor to the 16-bit mv/mvt/add/sub processor. Same 16-bit instruction word and Run/Done handshake, extended with:
- a configurable data width and immediate-extension mode
- logical ALU ops (and/or/xor)
- Z/N/C status flags
- illegal-opcode error reporting
- a register debug read port

It is the top-level datapath+control block driven by the board-level bench.

---
 rtl/proc_gen_if.sv | 24 ++
 rtl/proc_gen.sv | 136 +++++++++++++
 tb/tb_proc_gen.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/proc_gen_if.sv
// Handshake, instruction, status and debug signals of the proc_gen processor.
// DW must match the DW of the proc_gen instance it is bound to.
interface proc_gen_if #(
  parameter int DW = 16
);
  logic          Run;
  logic [15:0]   Din;
  logic          Done;
  logic          Err;
  logic [2:0]    Flags;
  logic [2:0]    DbgSel;
  logic [DW-1:0] DbgOut;
  logic [DW-1:0] BusWires;

  modport slave (
    input  Run, Din, DbgSel,
    output Done, Err, Flags, DbgOut, BusWires
  );

  modport master (
    output Run, Din, DbgSel,
    input  Done, Err, Flags, DbgOut, BusWires
  );
endinterface

// File: rtl/proc_gen.sv
// Parametrised multi-cycle processor: mv/mvt/add/sub/and/or/xor over eight DW-bit
// registers, Run/Done handshake, Z/N/C flags, illegal-opcode pulse and a debug read port.
module proc_gen #(
  parameter int DW           = 16,
  parameter bit SIGN_EXT_IMM = 1'b0
) (
  input  logic        CLOCK_50,
  input  logic        Rest,
  proc_gen_if.slave   bus
);

  localparam logic [1:0] T0 = 2'd0;
  localparam logic [1:0] T1 = 2'd1;
  localparam logic [1:0] T2 = 2'd2;
  localparam logic [1:0] T3 = 2'd3;

  localparam logic [2:0] OP_MV  = 3'd0;
  localparam logic [2:0] OP_MVT = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;
  localparam logic [2:0] OP_ILL = 3'd7;

  logic [1:0]    r_state;
  logic [15:0]   r_ir;
  logic [DW-1:0] r_regs [8];
  logic [DW-1:0] r_a;
  logic [DW-1:0] r_g;
  logic [2:0]    r_flags;

  logic [2:0]    w_op;
  logic [2:0]    w_rx;
  logic [2:0]    w_ry;
  logic [8:0]    w_imm9;
  logic [DW-1:0] w_imm_ext;
  logic [DW-1:0] w_mvt_val;
  logic [DW-1:0] w_y;
  logic          w_is_alu;
  logic [DW:0]   w_sum;
  logic [DW:0]   w_dif;
  logic [DW-1:0] w_res;
  logic          w_carry;
  logic [DW-1:0] w_bus;
  logic          w_write_rx;

  assign w_op   = r_ir[15:13];
  assign w_rx   = r_ir[11:9];
  assign w_ry   = r_ir[2:0];
  assign w_imm9 = r_ir[8:0];

  // Upper bits replicate imm9[8] only when sign extension is enabled.
  assign w_imm_ext = {{(DW-9){SIGN_EXT_IMM & w_imm9[8]}}, w_imm9};
  assign w_mvt_val = {w_imm9[7:0], {(DW-8){1'b0}}};
  assign w_y       = r_ir[12] ? w_imm_ext : r_regs[w_ry];
  assign w_is_alu  = (w_op >= OP_ADD) && (w_op <= OP_XOR);

  // The extra top bit of the difference is the borrow (set when A < Y unsigned).
  assign w_sum = {1'b0, r_a} + {1'b0, w_y};
  assign w_dif = {1'b0, r_a} - {1'b0, w_y};

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    w_res   = '0;
    w_carry = 1'b0;
    case (w_op)
      OP_ADD:  {w_carry, w_res} = w_sum;
      OP_SUB:  {w_carry, w_res} = w_dif;
      OP_AND:  w_res = r_a & w_y;
      OP_OR:   w_res = r_a | w_y;
      OP_XOR:  w_res = r_a ^ w_y;
      default: w_res = '0;
    endcase
  end

  always_comb begin
    w_bus = '0;
    case (r_state)
      T1: begin
        if (w_op == OP_MV)       w_bus = w_y;
        else if (w_op == OP_MVT) w_bus = w_mvt_val;
        else if (w_is_alu)       w_bus = r_regs[w_rx];
      end
      T2:      w_bus = w_y;
      T3:      w_bus = r_g;
      default: w_bus = '0;
    endcase
  end

  assign w_write_rx = ((r_state == T1) && ((w_op == OP_MV) || (w_op == OP_MVT)))
                    || (r_state == T3);

  always_ff @(posedge CLOCK_50 or negedge Rest) begin
    if (!Rest) begin
      r_state <= T0;
      r_ir    <= '0;
      r_a     <= '0;
      r_g     <= '0;
      r_flags <= '0;
      // NOTE: the register file is architecturally visible state, so it is cleared on reset too.
      for (int i = 0; i < 8; i++) r_regs[i] <= '0;
    end else begin
      case (r_state)
        T0: begin
          if (bus.Run) begin
            r_ir    <= bus.Din;
            r_state <= T1;
          end
        end
        T1: begin
          if (w_is_alu) begin
            r_a     <= w_bus;
            r_state <= T2;
          end else begin
            r_state <= T0;
          end
        end
        T2: begin
          r_g     <= w_res;
          r_flags <= {(w_res == '0), w_res[DW-1], w_carry};
          r_state <= T3;
        end
        default: r_state <= T0;
      endcase
      if (w_write_rx) r_regs[w_rx] <= w_bus;
    end
  end

  assign bus.Done     = ((r_state == T1) && !w_is_alu) || (r_state == T3);
  assign bus.Err      = (r_state == T1) && (w_op == OP_ILL);
  assign bus.Flags    = r_flags;
  assign bus.DbgOut   = r_regs[bus.DbgSel];
  assign bus.BusWires = w_bus;

endmodule

// File: tb/tb_proc_gen.sv
// Bench for proc_gen: a 16-bit zero-extending and a 32-bit sign-extending instance share
// one stimulus stream and are compared every cycle against an instruction-level model.
module tb_proc_gen;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  proc_gen_if #(.DW(16)) if0 ();
  proc_gen_if #(.DW(32)) if1 ();

  proc_gen #(.DW(16), .SIGN_EXT_IMM(1'b0)) dut0 (.CLOCK_50(clk), .Rest(rst_n), .bus(if0));
  proc_gen #(.DW(32), .SIGN_EXT_IMM(1'b1)) dut1 (.CLOCK_50(clk), .Rest(rst_n), .bus(if1));

  typedef struct packed {
    logic             done;
    logic             err;
    logic [1:0][2:0]  flags;
    logic [1:0][31:0] dbg;
  } exp_t;

  exp_t        q[$];
  exp_t        cmp_e;
  int          n_checks = 0;
  int          n_errors = 0;
  bit          running  = 1'b0;
  logic [31:0] m_regs [2][8];
  logic [2:0]  m_flags [2];
  logic [2:0]  dbg_sel;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_flags[k] = 3'b000;
      for (int i = 0; i < 8; i++) m_regs[k][i] = 32'h0;
    end
  endfunction

  // Instruction result and resulting flags for instance k (0: DW=16 zero-ext, 1: DW=32 sign-ext).
  function automatic void model_compute(input int k, input logic [15:0] ins,
                                        output logic [31:0] res, output logic [2:0] fl);
    int          dw;
    logic [31:0] mask, a, y;
    logic [8:0]  imm;
    logic [63:0] wide;
    logic        c;
    dw   = (k == 1) ? 32 : 16;
    mask = (k == 1) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    imm  = ins[8:0];
    a    = m_regs[k][ins[11:9]];
    if (ins[12]) y = ((k == 1) && imm[8]) ? ((mask & ~32'h1FF) | 32'(imm)) : 32'(imm);
    else         y = m_regs[k][ins[2:0]];
    c = 1'b0;
    case (ins[15:13])
      3'd0: res = y;
      3'd1: res = (32'(imm[7:0]) << (dw - 8)) & mask;
      3'd2: begin wide = 64'(a) + 64'(y); res = wide[31:0] & mask; c = wide[dw]; end
      3'd3: begin res = (a - y) & mask; c = (a < y); end
      3'd4: res = a & y;
      3'd5: res = a | y;
      3'd6: res = a ^ y;
      default: res = a;
    endcase
    fl = {(res == 32'h0), res[dw-1], c};
  endfunction

  task automatic drive(input logic run, input logic [15:0] din);
    if0.Run = run; if0.Din = din;
    if1.Run = run; if1.Din = din;
  endtask

  // Queue this cycle's expectation, then advance to just after the next rising edge.
  task automatic cycle(input logic done, input logic err);
    exp_t e;
    dbg_sel    = 3'($urandom);
    if0.DbgSel = dbg_sel;
    if1.DbgSel = dbg_sel;
    e.done = done;
    e.err  = err;
    for (int k = 0; k < 2; k++) begin
      e.flags[k] = m_flags[k];
      e.dbg[k]   = m_regs[k][dbg_sel];
    end
    q.push_back(e);
    running = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic exec(input logic [15:0] ins, input bit abort);
    logic [31:0] res [2];
    logic [2:0]  fl  [2];
    logic [2:0]  op;
    op = ins[15:13];
    for (int k = 0; k < 2; k++) model_compute(k, ins, res[k], fl[k]);
    drive(1'b1, ins);
    cycle(1'b0, 1'b0);
    drive(1'($urandom), 16'($urandom));
    if (op == 3'd0 || op == 3'd1 || op == 3'd7) begin
      cycle(1'b1, op == 3'd7);
      if (op != 3'd7) for (int k = 0; k < 2; k++) m_regs[k][ins[11:9]] = res[k];
    end else begin
      cycle(1'b0, 1'b0);
      if (abort) begin
        rst_n = 1'b0;
        model_reset();
        drive(1'b0, 16'h0);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        rst_n = 1'b1;
        cycle(1'b0, 1'b0);
        return;
      end
      cycle(1'b0, 1'b0);
      for (int k = 0; k < 2; k++) m_flags[k] = fl[k];
      cycle(1'b1, 1'b0);
      for (int k = 0; k < 2; k++) m_regs[k][ins[11:9]] = res[k];
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        cmp_e = q.pop_front();
        check("done16",  32'(if0.Done),   32'(cmp_e.done));
        check("err16",   32'(if0.Err),    32'(cmp_e.err));
        check("flags16", 32'(if0.Flags),  32'(cmp_e.flags[0]));
        check("dbg16",   32'(if0.DbgOut), cmp_e.dbg[0]);
        check("done32",  32'(if1.Done),   32'(cmp_e.done));
        check("err32",   32'(if1.Err),    32'(cmp_e.err));
        check("flags32", 32'(if1.Flags),  32'(cmp_e.flags[1]));
        check("dbg32",   if1.DbgOut,      cmp_e.dbg[1]);
      end else if (running) begin
        check("expect_queue_empty", 32'd0, 32'd1);
      end
    end
  end

  initial begin
    logic [15:0] ins;
    model_reset();
    drive(1'b0, 16'h0);
    if0.DbgSel = 3'd0;
    if1.DbgSel = 3'd0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    rst_n = 1'b1;
    cycle(1'b0, 1'b0);

    exec(16'h101C, 1'b0);
    check("pin_mv_r0", m_regs[0][0], 32'h0000_001C);
    exec(16'h32FF, 1'b0);
    check("pin_mvt16_r1", m_regs[0][1], 32'h0000_FF00);
    check("pin_mvt32_r1", m_regs[1][1], 32'hFF00_0000);
    exec(16'h52FF, 1'b0);
    check("pin_add_r1", m_regs[0][1], 32'h0000_FFFF);
    check("pin_add_flags", 32'(m_flags[0]), 32'b010);
    exec(16'h6200, 1'b0);
    check("pin_sub_r1", m_regs[0][1], 32'h0000_FFE3);
    check("pin_sub_flags", 32'(m_flags[0]), 32'b010);
    exec(16'h34FF, 1'b0);
    exec(16'h54FF, 1'b0);
    exec(16'h5401, 1'b0);
    check("pin_wrap_r2", m_regs[0][2], 32'h0);
    check("pin_wrap_flags", 32'(m_flags[0]), 32'b101);
    exec(16'hE000, 1'b0);
    check("pin_ill_flags", 32'(m_flags[0]), 32'b101);
    exec(16'h16F0, 1'b0);
    exec(16'h96FF, 1'b0);
    check("pin_and", m_regs[0][3], 32'h0000_00F0);
    exec(16'h16F0, 1'b0);
    exec(16'hB6FF, 1'b0);
    check("pin_or", m_regs[0][3], 32'h0000_00FF);
    exec(16'h16F0, 1'b0);
    exec(16'hD6FF, 1'b0);
    check("pin_xor", m_regs[0][3], 32'h0000_000F);
    exec(16'h17FF, 1'b0);
    check("pin_zext_r3", m_regs[0][3], 32'h0000_01FF);
    check("pin_sext_r3", m_regs[1][3], 32'hFFFF_FFFF);
    exec(16'h52FF, 1'b1);
    check("pin_abort_r3", m_regs[0][3], 32'h0);
    exec(16'h101C, 1'b0);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(3) == 0) begin
        drive(1'b0, 16'($urandom));
        cycle(1'b0, 1'b0);
      end
      ins = 16'($urandom);
      exec(ins, ($urandom_range(39) == 0) && (ins[15:13] >= 3'd2) && (ins[15:13] <= 3'd6));
    end

    running = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
